// File: rtl/pipe_check_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_check_pkg
// Purpose  : Shared encodings for the Pipe In checker and Pipe Out source:
//            pattern modes, checker status values, LFSR polynomial helper.
// Revision : 1.0  initial release
// ============================================================================
package pipe_check_pkg;

    // Expected-data modes; encodings 4-7 fall back to FIXED behaviour
    localparam logic [2:0] PAT_FIXED = 3'd0;
    localparam logic [2:0] PAT_COUNT = 3'd1;
    localparam logic [2:0] PAT_LFSR  = 3'd2;
    localparam logic [2:0] PAT_WALK1 = 3'd3;

    // Checker status as seen on the status port
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FAIL = 2'd2
    } status_e;

    // x^32 + x^22 + x^2 + x + 1, left-shifting Galois form (x^32 implied)
    localparam logic [31:0] LFSR_TAPS = 32'h0040_0007;

    // One Galois step: shift left, fold the outgoing MSB back into the taps
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        lfsr_next = {s[30:0], 1'b0} ^ (s[31] ? LFSR_TAPS : 32'h0000_0000);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_in_expect_gen.sv
`default_nettype none
// ============================================================================
// Module   : pipe_in_expect_gen
// Purpose  : Regenerates the expected Pipe In word stream. Presents the word
//            for the current position; advances once per accepted word.
// Revision : 1.0  initial release
// ============================================================================
module pipe_in_expect_gen
    import pipe_check_pkg::*;
#(
    parameter logic [31:0] LFSR_SEED = 32'h0D0C_0B0A
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        restart,
    input  logic        advance,
    input  logic [2:0]  mode,
    input  logic [31:0] fixed,
    output logic [31:0] exp_word_o
);

    // Each sequence keeps its own state so reset values are mode independent
    logic [31:0] count_q, count_d;
    logic [31:0] lfsr_q,  lfsr_d;
    logic [31:0] walk_q,  walk_d;

    // Next sequence state: restart wins over advance
    always_comb begin
        count_d = count_q;
        lfsr_d  = lfsr_q;
        walk_d  = walk_q;
        if (restart) begin
            count_d = 32'd1;
            lfsr_d  = LFSR_SEED;
            walk_d  = 32'd1;
        end else if (advance) begin
            count_d = count_q + 32'd1;
            lfsr_d  = lfsr_next(lfsr_q);
            walk_d  = {walk_q[30:0], walk_q[31]};
        end
    end

    // Sequence registers, start values on reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= 32'd1;
            lfsr_q  <= LFSR_SEED;
            walk_q  <= 32'd1;
        end else begin
            count_q <= count_d;
            lfsr_q  <= lfsr_d;
            walk_q  <= walk_d;
        end
    end

    // Select the word the selected mode expects at the current position
    always_comb begin
        exp_word_o = fixed;
        case (mode)
            PAT_FIXED: exp_word_o = fixed;
            PAT_COUNT: exp_word_o = count_q;
            PAT_LFSR:  exp_word_o = lfsr_q;
            PAT_WALK1: exp_word_o = walk_q;
            default:   exp_word_o = fixed;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/pipe_in_check.sv
`default_nettype none
// ============================================================================
// Module   : pipe_in_check
// Purpose  : Pipe In sink: compares each host word against a regenerated
//            pattern, counts words/errors, captures the first mismatch and
//            models a throttled virtual FIFO that drives pipe_in_ready.
// Revision : 1.0  initial release
// ============================================================================
module pipe_in_check
    import pipe_check_pkg::*;
#(
    parameter int unsigned LEVEL_MAX   = 65535,
    parameter int unsigned READY_SPACE = 1024,
    parameter logic [31:0] LFSR_SEED   = 32'h0D0C_0B0A
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        pipe_in_write,
    input  logic [31:0] pipe_in_data,
    output logic        pipe_in_ready,
    input  logic        throttle_set,
    input  logic [31:0] throttle_val,
    input  logic [31:0] fixed_pattern,
    input  logic [2:0]  pattern,
    output logic [31:0] word_count,
    output logic [31:0] error_count,
    output logic [31:0] first_err_idx,
    output logic [31:0] first_err_exp,
    output logic [31:0] first_err_rcv,
    output logic [1:0]  status,
    output logic        overflow
);

    localparam logic [15:0] C_LEVEL_MAX   = 16'(LEVEL_MAX);
    localparam logic [15:0] C_READY_SPACE = 16'(READY_SPACE);

    logic [31:0] w_exp;
    logic        w_accept;
    logic        w_mismatch;
    logic [31:0] w_ring;

    // Compare stage: word and its expected value, checked one cycle later
    logic        stg_vld_q, stg_vld_d;
    logic [31:0] stg_rcv_q, stg_rcv_d;
    logic [31:0] stg_exp_q, stg_exp_d;

    logic [31:0] word_cnt_q, word_cnt_d;
    logic [31:0] err_cnt_q,  err_cnt_d;
    logic [31:0] fidx_q, fidx_d;
    logic [31:0] fexp_q, fexp_d;
    logic [31:0] frcv_q, frcv_d;
    status_e     status_q, status_d;

    logic [15:0] level_q, level_d;
    logic        ovf_q, ovf_d;
    logic        ready_q, ready_d;
    logic [31:0] ring_q, ring_d;
    logic        ring_vld_q;

    // A word arriving together with clear is discarded entirely
    assign w_accept   = pipe_in_write && !clear;
    assign w_mismatch = stg_vld_q && (stg_rcv_q != stg_exp_q);
    // Until the ring is first loaded after reset it mirrors throttle_val
    assign w_ring     = ring_vld_q ? ring_q : throttle_val;

    pipe_in_expect_gen #(
        .LFSR_SEED (LFSR_SEED)
    ) u_expect_gen (
        .clk        (clk),
        .reset_n    (reset_n),
        .restart    (clear),
        .advance    (w_accept),
        .mode       (pattern),
        .fixed      (fixed_pattern),
        .exp_word_o (w_exp)
    );

    // Status FSM: IDLE until first good word, FAIL sticky until clear
    always_comb begin
        status_d = status_q;
        if (clear) begin
            status_d = ST_IDLE;
        end else if (stg_vld_q) begin
            if (w_mismatch) begin
                status_d = ST_FAIL;
            end else if (status_q == ST_IDLE) begin
                status_d = ST_RUN;
            end
        end
    end

    // Compare pipeline, counters and first-error capture
    always_comb begin
        stg_vld_d  = w_accept;
        stg_rcv_d  = pipe_in_data;
        stg_exp_d  = w_exp;
        word_cnt_d = word_cnt_q;
        err_cnt_d  = err_cnt_q;
        fidx_d     = fidx_q;
        fexp_d     = fexp_q;
        frcv_d     = frcv_q;
        if (clear) begin
            word_cnt_d = 32'd0;
            err_cnt_d  = 32'd0;
            fidx_d     = 32'd0;
            fexp_d     = 32'd0;
            frcv_d     = 32'd0;
        end else if (stg_vld_q) begin
            // Pre-increment count is the zero-based index of the staged word
            word_cnt_d = word_cnt_q + 32'd1;
            if (w_mismatch) begin
                if (err_cnt_q != 32'hFFFF_FFFF) begin
                    err_cnt_d = err_cnt_q + 32'd1;
                end
                if (status_q != ST_FAIL) begin
                    fidx_d = word_cnt_q;
                    fexp_d = stg_exp_q;
                    frcv_d = stg_rcv_q;
                end
            end
        end
    end

    // Virtual FIFO: writes fill, ring bit 0 drains, simultaneous cancel
    always_comb begin
        level_d = level_q;
        ovf_d   = ovf_q;
        ready_d = (C_LEVEL_MAX - level_q) >= C_READY_SPACE;
        ring_d  = throttle_set ? throttle_val : {w_ring[0], w_ring[31:1]};
        if (clear) begin
            level_d = 16'd0;
            ovf_d   = 1'b0;
            ready_d = 1'b0;
            ring_d  = throttle_val;
        end else begin
            case ({pipe_in_write, w_ring[0]})
                2'b10: begin
                    if (level_q == C_LEVEL_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        level_d = level_q + 16'd1;
                    end
                end
                2'b01: begin
                    if (level_q != 16'd0) begin
                        level_d = level_q - 16'd1;
                    end
                end
                default: level_d = level_q;
            endcase
        end
    end

    // All state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stg_vld_q  <= 1'b0;
            stg_rcv_q  <= 32'd0;
            stg_exp_q  <= 32'd0;
            word_cnt_q <= 32'd0;
            err_cnt_q  <= 32'd0;
            fidx_q     <= 32'd0;
            fexp_q     <= 32'd0;
            frcv_q     <= 32'd0;
            status_q   <= ST_IDLE;
            level_q    <= 16'd0;
            ovf_q      <= 1'b0;
            ready_q    <= 1'b0;
            ring_q     <= 32'd0;
            ring_vld_q <= 1'b0;
        end else begin
            stg_vld_q  <= stg_vld_d;
            stg_rcv_q  <= stg_rcv_d;
            stg_exp_q  <= stg_exp_d;
            word_cnt_q <= word_cnt_d;
            err_cnt_q  <= err_cnt_d;
            fidx_q     <= fidx_d;
            fexp_q     <= fexp_d;
            frcv_q     <= frcv_d;
            status_q   <= status_d;
            level_q    <= level_d;
            ovf_q      <= ovf_d;
            ready_q    <= ready_d;
            ring_q     <= ring_d;
            ring_vld_q <= 1'b1;
        end
    end

    assign pipe_in_ready = ready_q;
    assign word_count    = word_cnt_q;
    assign error_count   = err_cnt_q;
    assign first_err_idx = fidx_q;
    assign first_err_exp = fexp_q;
    assign first_err_rcv = frcv_q;
    assign status        = status_q;
    assign overflow      = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_in_check.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_in_check
// Purpose  : Self-checking bench for pipe_in_check against a behavioural
//            model of the word stream, counters and virtual FIFO level.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_in_check;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clear = 1'b0;
    logic        pipe_in_write = 1'b0;
    logic [31:0] pipe_in_data = 32'd0;
    logic        throttle_set = 1'b0;
    logic [31:0] throttle_val = 32'd0;
    logic [31:0] fixed_pattern = 32'd0;
    logic [2:0]  pattern = 3'd1;
    logic        pipe_in_ready;
    logic [31:0] word_count, error_count, first_err_idx, first_err_exp, first_err_rcv;
    logic [1:0]  status;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    // Model state
    bit [31:0] m_words, m_errs, m_fidx, m_fexp, m_frcv, m_gen, m_ring;
    int        m_status;
    int        m_level;
    bit        m_ovf, m_ready;
    bit [63:0] m_q[$];

    pipe_in_check dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .clear         (clear),
        .pipe_in_write (pipe_in_write),
        .pipe_in_data  (pipe_in_data),
        .pipe_in_ready (pipe_in_ready),
        .throttle_set  (throttle_set),
        .throttle_val  (throttle_val),
        .fixed_pattern (fixed_pattern),
        .pattern       (pattern),
        .word_count    (word_count),
        .error_count   (error_count),
        .first_err_idx (first_err_idx),
        .first_err_exp (first_err_exp),
        .first_err_rcv (first_err_rcv),
        .status        (status),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    function automatic bit [31:0] gen_start(input bit [2:0] md);
        case (md)
            3'd1:    return 32'd1;
            3'd2:    return 32'h0D0C_0B0A;
            3'd3:    return 32'd1;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit [31:0] gen_next(input bit [2:0] md, input bit [31:0] v);
        case (md)
            3'd1:    return v + 32'd1;
            3'd2:    return (v << 1) ^ (v[31] ? 32'h0040_0007 : 32'h0);
            3'd3:    return (v << 1) | (v >> 31);
            default: return v;
        endcase
    endfunction

    function automatic bit [31:0] exp_now();
        return (pattern >= 3'd1 && pattern <= 3'd3) ? m_gen : fixed_pattern;
    endfunction

    task automatic model_reset();
        m_words = 0; m_errs = 0; m_fidx = 0; m_fexp = 0; m_frcv = 0;
        m_status = 0; m_level = 0; m_ovf = 0; m_ready = 0;
        m_ring = throttle_val;
        m_gen = gen_start(pattern);
        m_q.delete();
    endtask

    // Advance the model by one rising edge using the inputs presented to it
    task automatic model_step();
        bit [63:0] it;
        if (!reset_n) begin
            model_reset();
            return;
        end
        if (clear) begin
            model_reset();
            return;
        end
        if (m_q.size() > 0) begin
            it = m_q.pop_front();
            if (it[63:32] != it[31:0]) begin
                if (m_errs != 32'hFFFF_FFFF) m_errs++;
                if (m_status != 2) begin
                    m_fidx = m_words; m_frcv = it[63:32]; m_fexp = it[31:0];
                end
                m_status = 2;
            end else if (m_status == 0) begin
                m_status = 1;
            end
            m_words++;
        end
        if (pipe_in_write) begin
            m_q.push_back({pipe_in_data, exp_now()});
            m_gen = gen_next(pattern, m_gen);
        end
        m_ready = (65535 - m_level) >= 1024;
        if (pipe_in_write && !m_ring[0]) begin
            if (m_level == 65535) m_ovf = 1'b1;
            else m_level++;
        end else if (!pipe_in_write && m_ring[0] && m_level > 0) begin
            m_level--;
        end
        m_ring = throttle_set ? throttle_val : {m_ring[0], m_ring[31:1]};
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_all();
        chk("word_count",    word_count,    m_words);
        chk("error_count",   error_count,   m_errs);
        chk("status",        {30'd0, status}, m_status);
        chk("pipe_in_ready", {31'd0, pipe_in_ready}, {31'd0, m_ready});
        chk("overflow",      {31'd0, overflow},      {31'd0, m_ovf});
        chk("first_err_idx", first_err_idx, m_fidx);
        chk("first_err_exp", first_err_exp, m_fexp);
        chk("first_err_rcv", first_err_rcv, m_frcv);
    endtask

    // One clock: model follows the edge, outputs sampled 1 after it
    task automatic tick(input bit check_all);
        @(posedge clk);
        model_step();
        #1;
        if (check_all) chk_all();
        @(negedge clk);
    endtask

    task automatic put(input logic [31:0] d);
        pipe_in_write = 1'b1;
        pipe_in_data  = d;
        tick(1'b0);
        pipe_in_write = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick(1'b1);
        clear = 1'b0;
    endtask

    initial begin
        int got_at;
        model_reset();
        // Reset held across two edges: every output must read zero
        tick(1'b1);
        tick(1'b1);
        reset_n = 1'b1;
        tick(1'b1);

        // COUNT mode clean stream of 4096 words
        for (int i = 1; i <= 4096; i++) put(32'(i));
        tick(1'b1);
        chk("count_words", word_count, 32'd4096);
        chk("count_errs",  error_count, 32'd0);
        chk("count_status", {30'd0, status}, 32'd1);
        chk("count_ovf",   {31'd0, overflow}, 32'd0);

        // COUNT mode with word index 10 corrupted
        do_clear();
        chk("clear_words", word_count, 32'd0);
        for (int i = 0; i < 20; i++) put((i == 10) ? 32'hDEAD_BEEF : 32'(i + 1));
        tick(1'b1);
        chk("err_status", {30'd0, status}, 32'd2);
        chk("err_idx",    first_err_idx, 32'd10);
        chk("err_exp",    first_err_exp, 32'd11);
        chk("err_rcv",    first_err_rcv, 32'hDEAD_BEEF);
        chk("err_count",  error_count, 32'd1);
        chk("err_words",  word_count, 32'd20);

        // clear coincident with a write discards that word
        clear = 1'b1; pipe_in_write = 1'b1; pipe_in_data = 32'd5;
        tick(1'b1);
        clear = 1'b0; pipe_in_write = 1'b0;
        tick(1'b1);
        chk("clrw_words", word_count, 32'd0);
        put(32'd1);
        tick(1'b1);
        chk("clrw_first_ok", error_count, 32'd0);
        chk("clrw_status",   {30'd0, status}, 32'd1);

        // LFSR burst cut by asynchronous reset
        pattern = 3'd2;
        do_clear();
        for (int i = 0; i < 8; i++) put(exp_now());
        pipe_in_write = 1'b1;
        pipe_in_data  = exp_now();
        reset_n = 1'b0;
        #1;
        model_reset();
        chk_all();
        chk("rst_words", word_count, 32'd0);
        pipe_in_write = 1'b0;
        @(negedge clk);
        tick(1'b1);
        reset_n = 1'b1;
        put(32'h0D0C_0B0A);
        tick(1'b1);
        chk("rst_lfsr_seed_errs", error_count, 32'd0);
        chk("rst_lfsr_status",    {30'd0, status}, 32'd1);

        // Randomised segments in every mode, checked each cycle
        for (int seg = 0; seg < 4; seg++) begin
            pattern       = 3'($urandom_range(0, 7));
            fixed_pattern = $urandom;
            throttle_val  = $urandom;
            do_clear();
            for (int c = 0; c < 600; c++) begin
                pipe_in_write = ($urandom_range(0, 2) != 0);
                pipe_in_data  = ($urandom_range(0, 15) == 0) ? $urandom : exp_now();
                throttle_set  = ($urandom_range(0, 31) == 0);
                if (throttle_set) throttle_val = $urandom;
                clear         = ($urandom_range(0, 199) == 0);
                tick(1'b1);
            end
            pipe_in_write = 1'b0; throttle_set = 1'b0; clear = 1'b0;
            tick(1'b1);
        end

        // Fill the virtual FIFO past capacity with draining disabled
        pattern = 3'd1;
        throttle_val = 32'd0;
        do_clear();
        for (int i = 1; i <= 65536; i++) put(32'(i));
        tick(1'b1);
        chk("fill_ovf",   {31'd0, overflow}, 32'd1);
        chk("fill_ready", {31'd0, pipe_in_ready}, 32'd0);
        chk("fill_words", word_count, 32'd65536);
        chk("fill_errs",  error_count, 32'd0);

        // Enable full-rate drain; ready returns once level <= 64511
        throttle_val = 32'hFFFF_FFFF;
        throttle_set = 1'b1;
        tick(1'b1);
        throttle_set = 1'b0;
        got_at = 0;
        for (int j = 1; j <= 2000 && got_at == 0; j++) begin
            tick(1'b1);
            if (pipe_in_ready) got_at = j;
        end
        chk("drain_ready_cycle", got_at, 32'd1025);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
